// File: rtl/cpu15_pkg.sv
// Shared CPU15 definitions used by both the RAM read decoder and the
// write side (ram_wt): address map, data width and the IO64 handshake
// state encoding.
package cpu15_pkg;

  localparam int DATA_W = 16;

  // Address map of the small data space.
  localparam logic [7:0] RAM_AD_MIN  = 8'd0;
  localparam logic [7:0] RAM_AD_MAX  = 8'd7;
  localparam logic [7:0] IO_OUT_ADDR = 8'd64;
  localparam logic [7:0] IO_IN_ADDR  = 8'd65;

  // IO64 output-port handshake states.
  typedef enum logic {
    IDLE = 1'b0,  // port empty, IO64_VALID low
    PEND = 1'b1   // data waiting for the device, IO64_VALID high
  } io_state_e;

  // True when an address selects one of the eight RAM words. The lower
  // bound is zero, so only the upper bound needs a compare.
  function automatic logic is_ram_addr(input logic [7:0] ad);
    return ad <= RAM_AD_MAX;
  endfunction

endpackage

// File: rtl/io_out_port.sv
// IO64 output port: data register plus a valid/ack handshake toward the
// external output device, and a sticky overflow flag for dropped writes.
//
// Ports:
//   clk    in   write clock, all state changes on posedge
//   reset  in   synchronous active-high reset
//   wr     in   write strobe (already decoded for the IO64 address)
//   din    in   write data
//   ack    in   device has consumed dout
//   dout   out  registered port data
//   valid  out  dout holds data not yet acknowledged
//   ovf    out  sticky: a write arrived while data was still pending
module io_out_port
  import cpu15_pkg::io_state_e;
  import cpu15_pkg::IDLE;
  import cpu15_pkg::PEND;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              ack,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              ovf
);

  io_state_e         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        // ack is meaningless with nothing pending.
        if (wr) begin
          data_d  = din;
          state_d = PEND;
        end
      end
      PEND: begin
        if (wr && ack) begin
          // The ack retires the old word in the same cycle, so the new
          // one takes its slot and the port stays pending.
          data_d = din;
        end else if (wr) begin
          ovf_d = 1'b1;
        end else if (ack) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign dout  = data_q;
  assign valid = (state_q == PEND);
  assign ovf   = ovf_q;

endmodule

// File: rtl/ram_wt.sv
// CPU15 RAM write side. Decodes the write-back address and stores data
// into eight RAM words (addresses 0..7) or the IO64 output port
// (IO_OUT_ADDR). All other addresses, including the input-only port 65,
// are ignored. All outputs are registered.
//
// Ports:
//   CLK_WT         in   write clock
//   RESET          in   synchronous active-high reset, beats any write
//   RAM_WEN        in   write enable from the write-back stage
//   RAM_AD_IN      in   write address
//   RAM_IN         in   write data
//   IO64_ACK       in   external device consumed IO64_OUT
//   RAM_0..RAM_7   out  stored RAM words, feed the read decoder
//   IO64_OUT       out  output-port data
//   IO64_VALID     out  IO64_OUT not yet acknowledged
//   IO64_OVF       out  sticky: an IO64 write was dropped
module ram_wt
  import cpu15_pkg::is_ram_addr;
#(
  parameter int         DATA_W      = cpu15_pkg::DATA_W,
  parameter logic [7:0] IO_OUT_ADDR = cpu15_pkg::IO_OUT_ADDR
) (
  input  logic              CLK_WT,
  input  logic              RESET,
  input  logic              RAM_WEN,
  input  logic [7:0]        RAM_AD_IN,
  input  logic [DATA_W-1:0] RAM_IN,
  input  logic              IO64_ACK,
  output logic [DATA_W-1:0] RAM_0,
  output logic [DATA_W-1:0] RAM_1,
  output logic [DATA_W-1:0] RAM_2,
  output logic [DATA_W-1:0] RAM_3,
  output logic [DATA_W-1:0] RAM_4,
  output logic [DATA_W-1:0] RAM_5,
  output logic [DATA_W-1:0] RAM_6,
  output logic [DATA_W-1:0] RAM_7,
  output logic [DATA_W-1:0] IO64_OUT,
  output logic              IO64_VALID,
  output logic              IO64_OVF
);

  logic [DATA_W-1:0] ram_q [8];
  logic              ram_we;
  logic              io_we;

  assign ram_we = RAM_WEN && is_ram_addr(RAM_AD_IN);
  assign io_we  = RAM_WEN && (RAM_AD_IN == IO_OUT_ADDR);

  // NOTE: the eight words are discrete flops that drive output ports
  // directly, not an inferred RAM array, so clearing them all on reset
  // is legal and the read side relies on seeing zeros after reset.
  always_ff @(posedge CLK_WT) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) ram_q[i] <= '0;
    end else if (ram_we) begin
      // NOTE: non-blocking assignment for all clocked state, so every
      // register samples pre-edge values regardless of statement order.
      ram_q[RAM_AD_IN[2:0]] <= RAM_IN;
    end
  end

  assign RAM_0 = ram_q[0];
  assign RAM_1 = ram_q[1];
  assign RAM_2 = ram_q[2];
  assign RAM_3 = ram_q[3];
  assign RAM_4 = ram_q[4];
  assign RAM_5 = ram_q[5];
  assign RAM_6 = ram_q[6];
  assign RAM_7 = ram_q[7];

  io_out_port #(
    .DATA_W (DATA_W)
  ) u_io_out_port (
    .clk   (CLK_WT),
    .reset (RESET),
    .wr    (io_we),
    .din   (RAM_IN),
    .ack   (IO64_ACK),
    .dout  (IO64_OUT),
    .valid (IO64_VALID),
    .ovf   (IO64_OVF)
  );

endmodule

// File: tb/tb_ram_wt.sv
// Bench for ram_wt: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_ram_wt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wen = 1'b0;
  logic [7:0]  ad  = '0;
  logic [15:0] din = '0;
  logic        ack = 1'b0;

  logic [15:0] ram_out [8];
  logic [15:0] io_out;
  logic        io_valid;
  logic        io_ovf;

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  // Behavioural model state.
  logic [15:0] m_ram [8];
  logic [15:0] m_data;
  bit          m_valid;
  bit          m_ovf;

  always #5 clk = ~clk;

  ram_wt dut (
    .CLK_WT     (clk),
    .RESET      (rst),
    .RAM_WEN    (wen),
    .RAM_AD_IN  (ad),
    .RAM_IN     (din),
    .IO64_ACK   (ack),
    .RAM_0      (ram_out[0]),
    .RAM_1      (ram_out[1]),
    .RAM_2      (ram_out[2]),
    .RAM_3      (ram_out[3]),
    .RAM_4      (ram_out[4]),
    .RAM_5      (ram_out[5]),
    .RAM_6      (ram_out[6]),
    .RAM_7      (ram_out[7]),
    .IO64_OUT   (io_out),
    .IO64_VALID (io_valid),
    .IO64_OVF   (io_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the ack (if any) frees the slot first; a write to IO64 is
  // accepted only into a free slot, otherwise it only raises overflow.
  always @(posedge clk) begin
    bit busy;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_ram[i] = '0;
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      busy = m_valid && !ack;
      if (wen && ad < 8) m_ram[ad[2:0]] = din;
      if (wen && ad == 8'd64) begin
        if (busy) m_ovf = 1'b1;
        else begin
          m_data  = din;
          m_valid = 1'b1;
        end
      end else begin
        m_valid = busy;
      end
    end
  end

  // Every-cycle comparison, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 8; i++) check($sformatf("model ram_%0d", i), 32'(ram_out[i]), 32'(m_ram[i]));
      check("model io64_out", 32'(io_out), 32'(m_data));
      check("model io64_valid", 32'(io_valid), 32'(m_valid));
      check("model io64_ovf", 32'(io_ovf), 32'(m_ovf));
    end
  end

  // Apply one cycle of inputs, then settle just after the sampling edge.
  task automatic cyc(input logic r, input logic w, input logic [7:0] a,
                     input logic [15:0] d, input logic k);
    rst = r; wen = w; ad = a; din = d; ack = k;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s ram_%0d", tag, i), 32'(ram_out[i]), 32'h0);
    check({tag, " io64_out"}, 32'(io_out), 32'h0);
    check({tag, " io64_valid"}, 32'(io_valid), 32'h0);
    check({tag, " io64_ovf"}, 32'(io_ovf), 32'h0);
  endtask

  initial begin
    logic [15:0] v;
    int          r;

    // 1. Reset for two cycles, then idle.
    cyc(1, 0, 8'd0, 16'h0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 8'd0, 16'h0, 0);
    cyc(0, 0, 8'd0, 16'h0, 0);
    check_all_zero("reset");

    // 2. Fill the RAM words one per cycle; later words must still be zero.
    for (int n = 0; n < 8; n++) begin
      v = 16'h1111 * 16'(n + 1);
      cyc(0, 1, 8'(n), v, 0);
      check($sformatf("fill ram_%0d", n), 32'(ram_out[n]), 32'(v));
      if (n < 7) check($sformatf("fill hold ram_%0d", n + 1), 32'(ram_out[n + 1]), 32'h0);
    end
    cyc(0, 0, 8'd3, 16'hFFFF, 0);
    check("wen0 ram_3", 32'(ram_out[3]), 32'h4444);

    // 3. Unmapped addresses leave everything alone.
    cyc(0, 1, 8'd65, 16'hBEEF, 0);
    cyc(0, 1, 8'd8, 16'h1234, 0);
    cyc(0, 0, 8'd0, 16'h0, 0);
    check("unmapped ram_0", 32'(ram_out[0]), 32'h1111);
    check("unmapped ram_7", 32'(ram_out[7]), 32'h8888);
    check("unmapped io64_out", 32'(io_out), 32'h0);
    check("unmapped io64_valid", 32'(io_valid), 32'h0);

    // 4. IO64 write, hold without ack, then ack.
    cyc(0, 1, 8'd64, 16'hA5A5, 0);
    check("io write out", 32'(io_out), 32'hA5A5);
    check("io write valid", 32'(io_valid), 32'h1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 8'd0, 16'h0, 0);
      check("io hold valid", 32'(io_valid), 32'h1);
    end
    cyc(0, 0, 8'd0, 16'h0, 1);
    check("io ack valid", 32'(io_valid), 32'h0);
    check("io ack out", 32'(io_out), 32'hA5A5);

    // 5. Overflow, then write-with-ack replacement.
    cyc(0, 1, 8'd64, 16'h0001, 0);
    cyc(0, 1, 8'd64, 16'h0002, 0);
    check("ovf out", 32'(io_out), 32'h0001);
    check("ovf flag", 32'(io_ovf), 32'h1);
    cyc(0, 1, 8'd64, 16'h0003, 1);
    check("ack+wr out", 32'(io_out), 32'h0003);
    check("ack+wr valid", 32'(io_valid), 32'h1);
    check("ack+wr ovf", 32'(io_ovf), 32'h1);

    // 6. Reset while pending beats a simultaneous write (one address per cycle).
    cyc(1, 1, 8'd0, 16'h7777, 0);
    check_all_zero("rst+wr0");
    cyc(0, 1, 8'd64, 16'h0042, 0);
    check("repend valid", 32'(io_valid), 32'h1);
    cyc(1, 1, 8'd64, 16'h5555, 0);
    check_all_zero("rst+wr64");

    // Randomized traffic, checked by the model every cycle.
    for (int t = 0; t < 3000; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      ad = 8'($urandom_range(0, 7));
      else if (r < 7) ad = 8'd64;
      else if (r < 8) ad = 8'd65;
      else            ad = 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ad,
          16'($urandom), 1'($urandom_range(0, 1)));
    end
    cyc(0, 0, 8'd0, 16'h0, 0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
